// File: rtl/gpr_sequencer.sv
// Single-issue sequencer: GPR read, execute handshake with watchdog, optional
// GPR write-back (including multiplier-high byte), then a one-cycle done pulse.
module gpr_sequencer #(
    parameter int EXE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issueValid,
    output logic       issueReady,
    input  logic [2:0] issueA_num,
    input  logic [2:0] issueB_num,
    input  logic [2:0] issueC_num,
    input  logic       issueWriteBack,
    input  logic       issueMulOp,
    output logic       gprReadEn,
    output logic       gprWriteEn,
    output logic [2:0] gprA_num,
    output logic [2:0] gprB_num,
    output logic [2:0] gprC_num,
    output logic [7:0] gprC_in,
    output logic [7:0] gprMulHighIn,
    input  logic [7:0] gprA_data,
    input  logic [7:0] gprB_data,
    output logic       exeValid,
    output logic [7:0] exeA,
    output logic [7:0] exeB,
    input  logic       exeDone,
    input  logic [7:0] exeResult,
    input  logic [7:0] exeResultHigh,
    output logic       done,
    output logic       errTimeout,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;

    localparam logic [7:0] WDOG_LAST = 8'(EXE_TIMEOUT - 1);

    state_t     state;
    state_t     nxt;
    logic [2:0] a_num;
    logic [2:0] b_num;
    logic [2:0] c_num;
    logic       wb_flag;
    logic       mul_flag;
    logic       timeout_flag;
    logic [7:0] wdog;
    logic [7:0] res_lo;
    logic [7:0] res_hi;
    logic       ready_q;
    logic       read_q;
    logic       exec_q;
    logic       write_q;
    logic       resp_q;
    logic       busy_q;
    logic       accept;

    assign accept = issueValid & issueReady;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = READ;
            READ:    nxt = EXEC;
            EXEC: begin
                if (exeDone)                nxt = wb_flag ? WRITE : RESP;
                else if (wdog == WDOG_LAST) nxt = RESP;
            end
            WRITE:   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Output strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_num        <= '0;
            b_num        <= '0;
            c_num        <= '0;
            wb_flag      <= 1'b0;
            mul_flag     <= 1'b0;
            wdog         <= '0;
            timeout_flag <= 1'b0;
            ready_q      <= 1'b1;
            read_q       <= 1'b0;
            exec_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state   <= nxt;
            ready_q <= (nxt == IDLE);
            read_q  <= (nxt == READ);
            exec_q  <= (nxt == EXEC);
            write_q <= (nxt == WRITE);
            resp_q  <= (nxt == RESP);
            busy_q  <= (nxt != IDLE);
            if (state == IDLE && accept) begin
                a_num        <= issueA_num;
                b_num        <= issueB_num;
                c_num        <= issueC_num;
                wb_flag      <= issueWriteBack;
                mul_flag     <= issueMulOp;
                wdog         <= '0;
                timeout_flag <= 1'b0;
            end
            if (state == EXEC) begin
                wdog <= wdog + 8'd1;
                if (!exeDone && wdog == WDOG_LAST) timeout_flag <= 1'b1;
            end
        end
    end

    // Result bytes are pure data and need no reset.
    always_ff @(posedge clk) begin
        if (state == EXEC && exeDone) begin
            res_lo <= exeResult;
            res_hi <= exeResultHigh;
        end
    end

    // Every output is forced low while reset is asserted.
    assign issueReady   = ready_q & ~rst;
    assign gprReadEn    = read_q & ~rst;
    assign gprWriteEn   = write_q & ~rst;
    assign exeValid     = exec_q & ~rst;
    assign done         = resp_q & ~rst;
    assign busy         = busy_q & ~rst;
    assign errTimeout   = done & timeout_flag;
    assign gprA_num     = rst ? 3'd0 : a_num;
    assign gprB_num     = rst ? 3'd0 : b_num;
    assign gprC_num     = rst ? 3'd0 : c_num;
    assign exeA         = exeValid ? gprA_data : 8'h00;
    assign exeB         = exeValid ? gprB_data : 8'h00;
    assign gprC_in      = gprWriteEn ? res_lo : 8'h00;
    assign gprMulHighIn = (gprWriteEn && mul_flag) ? res_hi : 8'h00;

endmodule

// File: tb/tb_gpr_sequencer.sv
// Bench for gpr_sequencer: directed table, back-pressure, reset and random ops
// against a cycle-schedule model plus a reference register file.
module tb_gpr_sequencer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       issueValid;
    logic       issueReady;
    logic [2:0] issueA_num, issueB_num, issueC_num;
    logic       issueWriteBack, issueMulOp;
    logic       gprReadEn, gprWriteEn;
    logic [2:0] gprA_num, gprB_num, gprC_num;
    logic [7:0] gprC_in, gprMulHighIn;
    logic [7:0] gprA_data = 8'h00;
    logic [7:0] gprB_data = 8'h00;
    logic       exeValid;
    logic [7:0] exeA, exeB;
    logic       exeDone;
    logic [7:0] exeResult, exeResultHigh;
    logic       done, errTimeout, busy;

    always #5 clk = ~clk;

    gpr_sequencer #(.EXE_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .issueValid(issueValid), .issueReady(issueReady),
        .issueA_num(issueA_num), .issueB_num(issueB_num), .issueC_num(issueC_num),
        .issueWriteBack(issueWriteBack), .issueMulOp(issueMulOp),
        .gprReadEn(gprReadEn), .gprWriteEn(gprWriteEn),
        .gprA_num(gprA_num), .gprB_num(gprB_num), .gprC_num(gprC_num),
        .gprC_in(gprC_in), .gprMulHighIn(gprMulHighIn),
        .gprA_data(gprA_data), .gprB_data(gprB_data),
        .exeValid(exeValid), .exeA(exeA), .exeB(exeB),
        .exeDone(exeDone), .exeResult(exeResult), .exeResultHigh(exeResultHigh),
        .done(done), .errTimeout(errTimeout), .busy(busy)
    );

    // GPR file environment with registered read outputs
    logic [7:0] mem [8];
    logic [7:0] mem_mh = 8'h00;
    logic       ld_en = 1'b0;
    logic [2:0] ld_idx = 3'd0;
    logic [7:0] ld_val = 8'h00;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (gprWriteEn) begin
            mem[gprC_num] <= gprC_in;
            mem_mh        <= gprMulHighIn;
        end
        if (gprReadEn) begin
            gprA_data <= mem[gprA_num];
            gprB_data <= mem[gprB_num];
        end
    end

    logic [7:0] ref_rf [8];
    logic [7:0] ref_mh;
    bit         mh_known = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [2:0] a, b, c;
        logic       wb, mul;
        int         delay;      // EXEC cycle (1-based) in which exeDone rises; outside 1..T = never
        logic [7:0] lo, hi;
        int         exp_done;   // expected done cycle after accept; <=0 = not tabulated
        logic       exp_err;
        int         exp_writes;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [7:0] val);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        tick();
        ld_en = 1'b0;
        ref_rf[idx] = val;
    endtask

    task automatic junk_issue();
        issueA_num = 3'($urandom); issueB_num = 3'($urandom); issueC_num = 3'($urandom);
        issueWriteBack = 1'($urandom); issueMulOp = 1'($urandom);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.a = 3'($urandom); v.b = 3'($urandom); v.c = 3'($urandom);
        v.wb = 1'($urandom); v.mul = 1'($urandom);
        v.delay = $urandom_range(0, T + 1);
        v.lo = 8'($urandom); v.hi = 8'($urandom);
        v.exp_done = -1; v.exp_err = 1'b0; v.exp_writes = 0;
        return v;
    endfunction

    // Called in an IDLE window; returns in the IDLE window after the op.
    task automatic run_op(input vec_t v, input bit keep);
        bit tmo, wr, in_exec;
        int n_exec, resp, done_at, wr_count;
        logic err_obs;
        logic [5:0] ctrl_exp;
        tmo    = !(v.delay >= 1 && v.delay <= T);
        n_exec = tmo ? T : v.delay;
        wr     = !tmo && v.wb;
        resp   = 2 + n_exec + (wr ? 1 : 0);
        done_at = -1; wr_count = 0; err_obs = 1'b0;

        issueValid = 1'b1;
        issueA_num = v.a; issueB_num = v.b; issueC_num = v.c;
        issueWriteBack = v.wb; issueMulOp = v.mul;
        exeDone = 1'b0;
        #1;
        chk("idle_ready_busy", {issueReady, busy}, 2'b10);

        for (int k = 1; k <= resp; k++) begin
            tick();
            issueValid = keep;
            if (keep) junk_issue();
            in_exec = (k >= 2) && (k < 2 + n_exec);
            exeDone = in_exec ? (k == 1 + v.delay) : 1'($urandom);
            exeResult     = (in_exec && k == 1 + v.delay) ? v.lo : 8'($urandom);
            exeResultHigh = (in_exec && k == 1 + v.delay) ? v.hi : 8'($urandom);
            #1;
            ctrl_exp = {1'b0, k == 1, wr && (k == 2 + n_exec), in_exec, k == resp, 1'b1};
            chk("ctrl", {issueReady, gprReadEn, gprWriteEn, exeValid, done, busy}, ctrl_exp);
            chk("reg_nums", {gprA_num, gprB_num, gprC_num}, {v.a, v.b, v.c});
            if (in_exec) chk("operands", {exeA, exeB}, {ref_rf[v.a], ref_rf[v.b]});
            if (wr && k == 2 + n_exec)
                chk("wdata", {gprC_in, gprMulHighIn}, {v.lo, (v.mul ? v.hi : 8'h00)});
            if (k == resp) chk("err_timeout", errTimeout, tmo);
            if (done && done_at < 0) begin
                done_at = k;
                err_obs = errTimeout;
            end
            if (gprWriteEn) wr_count++;
        end

        if (v.exp_done > 0) begin
            chk("tbl_done_cycle", done_at, v.exp_done);
            chk("tbl_err", err_obs, v.exp_err);
            chk("tbl_writes", wr_count, v.exp_writes);
        end
        if (wr) begin
            ref_rf[v.c] = v.lo;
            ref_mh = v.mul ? v.hi : 8'h00;
            mh_known = 1;
        end
        tick();
        issueValid = keep;
        if (keep) junk_issue();
        exeDone = 1'b0;
        chk("rf_entry", mem[v.c], ref_rf[v.c]);
        if (mh_known) chk("rf_mulhigh", mem_mh, ref_mh);
    endtask

    function automatic logic [47:0] all_outs();
        return {issueReady, gprReadEn, gprWriteEn, gprA_num, gprB_num, gprC_num,
                gprC_in, gprMulHighIn, exeValid, exeA, exeB, done, errTimeout, busy};
    endfunction

    initial begin
        vec_t v;
        rst = 1'b1;
        issueValid = 1'b1;
        junk_issue();
        exeDone = 1'b1; exeResult = 8'h00; exeResultHigh = 8'h00;

        tbl[0] = '{a:3'd1, b:3'd2, c:3'd3, wb:1'b1, mul:1'b0, delay:1, lo:8'h46, hi:8'h77,
                   exp_done:4, exp_err:1'b0, exp_writes:1};
        tbl[1] = '{a:3'd3, b:3'd5, c:3'd6, wb:1'b1, mul:1'b1, delay:3, lo:8'hA0, hi:8'h05,
                   exp_done:6, exp_err:1'b0, exp_writes:1};
        tbl[2] = '{a:3'd6, b:3'd3, c:3'd7, wb:1'b0, mul:1'b1, delay:1, lo:8'h99, hi:8'h11,
                   exp_done:3, exp_err:1'b0, exp_writes:0};
        tbl[3] = '{a:3'd2, b:3'd1, c:3'd4, wb:1'b1, mul:1'b1, delay:0, lo:8'hEE, hi:8'hDD,
                   exp_done:6, exp_err:1'b1, exp_writes:0};
        tbl[4] = '{a:3'd4, b:3'd6, c:3'd5, wb:1'b1, mul:1'b1, delay:4, lo:8'h5A, hi:8'hC3,
                   exp_done:7, exp_err:1'b0, exp_writes:1};

        // Power-on reset
        tick();
        chk("rst_outs_0", all_outs(), 48'h0);
        tick();
        chk("rst_outs_1", all_outs(), 48'h0);
        rst = 1'b0; issueValid = 1'b0; exeDone = 1'b0;
        #1;
        chk("post_rst_ready_busy", {issueReady, busy}, 2'b10);
        chk("post_rst_nums", {gprA_num, gprB_num, gprC_num}, 9'd0);

        for (int i = 0; i < 8; i++) load(3'(i), 8'($urandom));
        load(3'd1, 8'h12);
        load(3'd2, 8'h34);

        for (int i = 0; i < 5; i++) run_op(tbl[i], 1'b0);

        // Back-pressure: issueValid never drops, one accept per 5 cycles
        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            v.wb = 1'b1; v.delay = 1;
            v.exp_done = 4; v.exp_writes = 1; v.exp_err = 1'b0;
            run_op(v, 1'b1);
        end
        issueValid = 1'b0;

        for (int i = 0; i < 30; i++) begin
            v = rand_vec();
            run_op(v, 1'($urandom));
        end
        issueValid = 1'b0;
        #1;
        chk("rand_end_idle", {issueReady, busy}, 2'b10);

        // Reset held 3 cycles in the middle of EXEC
        issueValid = 1'b1; issueA_num = 3'd1; issueB_num = 3'd2; issueC_num = 3'd0;
        issueWriteBack = 1'b1; issueMulOp = 1'b1;
        tick();
        issueValid = 1'b0;
        tick();
        chk("mid_exec_valid", exeValid, 1'b1);
        rst = 1'b1; exeDone = 1'b1; exeResult = 8'hFF; exeResultHigh = 8'hFF; issueValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_rst_outs", all_outs(), 48'h0);
            tick();
        end
        rst = 1'b0; issueValid = 1'b0; exeDone = 1'b0;
        #1;
        chk("mid_rst_ready_busy", {issueReady, busy}, 2'b10);
        for (int i = 0; i < 6; i++) begin
            tick();
            exeDone = 1'($urandom);
            #1;
            chk("after_rst_quiet", {issueReady, gprReadEn, gprWriteEn, exeValid, done, busy},
                6'b100000);
        end
        chk("after_rst_rf", mem[0], ref_rf[0]);
        exeDone = 1'b0;

        v = rand_vec();
        v.delay = 2; v.wb = 1'b1;
        v.exp_done = 5; v.exp_writes = 1; v.exp_err = 1'b0;
        run_op(v, 1'b0);
        issueValid = 1'b0;
        #1;
        chk("final_idle", {issueReady, busy}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "time limit");
    end

endmodule
